// File: rtl/riscv_lsu_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : riscv_lsu_bus_master
//  Brief    : Load/store initiator for the core req/gnt/rvalid data bus.
//             Takes one core access at a time, places data and strobes on the
//             right byte lanes of the 64-bit bus and returns the
//             sign/zero-extended load value as a one-cycle response.
//             Optional watchdog: define LSU_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_lsu_bus_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [63:0]       in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [63:0]       in_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              resp_err,
  output logic              req,
  output logic              wren,
  output logic [ADDR_W-1:0] addr,
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  input  logic              gnt,
  input  logic [63:0]       rdata,
  input  logic              rvalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Attributes of the access in flight, needed to extract the load value
  logic [2:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_we;

  logic [2:0]  w_off;
  logic        w_accept;
  logic        w_misalign;
  logic        w_timeout;
  logic [63:0] w_st_mask;
  logic [7:0]  w_strb_base;
  logic [63:0] w_st_data;
  logic [7:0]  w_st_strb;
  logic [63:0] w_ld_sh;
  logic [63:0] w_ld_ext;

  assign w_off    = in_addr[2:0];
  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  // Only the low ADDR_W address bits reach the bus
  generate
    if (ADDR_W < 64) begin : g_addr_unused
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^in_addr[63:ADDR_W];
    end
  endgenerate

`ifdef LSU_TIMEOUT_EN
  logic [31:0] r_cnt;

  // Watchdog counter: restarts on every bus access, runs while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // A response arriving on the expiry edge completes normally
  assign w_timeout = (r_state != S_IDLE) && (r_cnt == 32'(TIMEOUT_CYCLES - 1)) &&
                     !((r_state == S_WAIT) && rvalid);
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // Misalignment check: offset must be a multiple of the access size
  always_comb begin
    w_misalign = 1'b0;
    case (in_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = w_off[0];
      2'd2:    w_misalign = |w_off[1:0];
      default: w_misalign = |w_off;
    endcase
  end

  // Store lane placement: trim data to size, then shift to the byte offset
  always_comb begin
    w_st_mask   = '0;
    w_strb_base = '0;
    case (in_size)
      2'd0:    begin w_st_mask = 64'h0000_0000_0000_00FF; w_strb_base = 8'h01; end
      2'd1:    begin w_st_mask = 64'h0000_0000_0000_FFFF; w_strb_base = 8'h03; end
      2'd2:    begin w_st_mask = 64'h0000_0000_FFFF_FFFF; w_strb_base = 8'h0F; end
      default: begin w_st_mask = 64'hFFFF_FFFF_FFFF_FFFF; w_strb_base = 8'hFF; end
    endcase
    w_st_data = (in_wdata & w_st_mask) << {w_off, 3'b000};
    w_st_strb = w_strb_base << w_off;
  end

  // Load extraction: right-justify the addressed bytes and extend
  always_comb begin
    w_ld_sh  = rdata >> {r_off, 3'b000};
    w_ld_ext = w_ld_sh;
    case (r_size)
      2'd0:    w_ld_ext = {{56{~r_uns & w_ld_sh[7]}},  w_ld_sh[7:0]};
      2'd1:    w_ld_ext = {{48{~r_uns & w_ld_sh[15]}}, w_ld_sh[15:0]};
      2'd2:    w_ld_ext = {{32{~r_uns & w_ld_sh[31]}}, w_ld_sh[31:0]};
      default: w_ld_ext = w_ld_sh;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; stray gnt/rvalid outside their phase are ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_misalign) w_state_nxt = S_REQ;
      S_REQ:  if (w_timeout) w_state_nxt = S_IDLE;
              else if (gnt) w_state_nxt = S_WAIT;
      S_WAIT: if (rvalid || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered bus and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req           <= 1'b0;
      wren          <= 1'b0;
      addr          <= '0;
      wdata         <= '0;
      wstrb         <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      resp_err      <= 1'b0;
      r_off         <= '0;
      r_size        <= '0;
      r_uns         <= 1'b0;
      r_we          <= 1'b0;
    end else begin
      resp_valid    <= 1'b0;
      resp_misalign <= 1'b0;
      resp_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_misalign) begin
              resp_valid    <= 1'b1;
              resp_misalign <= 1'b1;
              resp_rdata    <= '0;
            end else begin
              req    <= 1'b1;
              wren   <= in_we;
              addr   <= in_addr[ADDR_W-1:0];
              wdata  <= in_we ? w_st_data : 64'd0;
              wstrb  <= in_we ? w_st_strb : 8'd0;
              r_off  <= w_off;
              r_size <= in_size;
              r_uns  <= in_unsigned;
              r_we   <= in_we;
            end
          end
        end
        S_REQ: begin
          if (w_timeout) begin
            req        <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (gnt) begin
            req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rvalid) begin
            resp_valid <= 1'b1;
            resp_rdata <= r_we ? 64'd0 : w_ld_ext;
          end else if (w_timeout) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        default: req <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_riscv_lsu_bus_master
//  Brief    : Self-checking bench for riscv_lsu_bus_master with a response
//             scoreboard. Timeout scenario runs when LSU_TIMEOUT_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_we, in_unsigned;
  logic [63:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        resp_valid, resp_misalign, resp_err;
  logic [63:0] resp_rdata;
  logic        req, wren, gnt, rvalid;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        mis;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_lsu_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_addr(in_addr),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_wdata(in_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .resp_err(resp_err),
    .req(req), .wren(wren), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid)
  );

  // Present one request for one cycle; returns just after the accepting edge
  task automatic send(input logic we, input logic [63:0] a, input logic [1:0] sz,
                      input logic uns, input logic [63:0] wd);
    in_valid = 1'b1; in_we = we; in_addr = a; in_size = sz;
    in_unsigned = uns; in_wdata = wd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Bus responder: grant after gnt_delay cycles, rvalid one cycle later.
  // Reports observed request cycles and the lane values; performs no checks.
  task automatic serve(input int gnt_delay, input logic [63:0] bus_rdata,
                       output int req_cyc, output logic stable, output logic req_after,
                       output logic [31:0] oa, output logic [63:0] owd,
                       output logic [7:0] ows, output logic owe);
    logic seen;
    req_cyc = 0; stable = 1'b1; oa = '0; owd = '0; ows = '0; owe = 1'b0;
    for (int i = 0; i < 40; i++) begin
      gnt = (i >= gnt_delay);
      @(negedge clk);
      seen = req;
      if (seen) begin
        if (req_cyc == 0) begin
          oa = addr; owd = wdata; ows = wstrb; owe = wren;
        end else if (addr !== oa || wdata !== owd || wstrb !== ows || wren !== owe) begin
          stable = 1'b0;
        end
        req_cyc++;
      end
      @(posedge clk); #1;
      if (seen && gnt) break;
    end
    gnt = 1'b0; rvalid = 1'b1; rdata = bus_rdata;
    @(negedge clk);
    req_after = req;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req, wren, resp_valid, resp_misalign, resp_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000", {req, wren, resp_valid, resp_misalign, resp_err});
    end
    checks++;
    if (addr !== 32'd0 || wdata !== 64'd0 || wstrb !== 8'd0 || resp_rdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h wstrb=%h rdata=%h want all 0", addr, wdata, wstrb, resp_rdata);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load_dword();
    int rc; logic st, ra, we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; exp_t e;
    send(1'b0, 64'h4000, 2'd3, 1'b0, 64'h0);
    sb.push_back('{64'h1122334455667788, 1'b0, 1'b0});
    serve(0, 64'h1122334455667788, rc, st, ra, a, wd, ws, we);
    checks++;
    if (rc !== 1 || ra !== 1'b0) begin
      failures++; $display("FAIL ld_req_cycles got=%0d/%b want=1/0", rc, ra);
    end
    checks++;
    if (a !== 32'h4000 || ws !== 8'h00 || we !== 1'b0) begin
      failures++; $display("FAIL ld_bus addr=%h wstrb=%h wren=%b want 4000/00/0", a, ws, we);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL ld_resp_valid got=%b want=1", resp_valid); sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if ({resp_rdata, resp_misalign, resp_err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL ld_resp got=%h/%b/%b want=%h/%b/%b", resp_rdata, resp_misalign, resp_err, e.rdata, e.mis, e.err);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_ext();
    int rc; logic st, ra, we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; exp_t e;
    logic [63:0] want [2];
    want[0] = 64'hFFFF_FFFF_FFFF_FF80;
    want[1] = 64'h0000_0000_0000_0080;
    for (int u = 0; u < 2; u++) begin
      send(1'b0, 64'h4005, 2'd0, u[0], 64'h0);
      sb.push_back('{want[u], 1'b0, 1'b0});
      serve(0, 64'h0000_8000_0000_0000, rc, st, ra, a, wd, ws, we);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL byte_resp_valid uns=%0d got=%b want=1", u, resp_valid); sb.delete();
      end else begin
        e = sb.pop_front();
        checks++;
        if (resp_rdata !== e.rdata) begin
          failures++; $display("FAIL byte_ext uns=%0d got=%h want=%h", u, resp_rdata, e.rdata);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_half_stall();
    int rc; logic st, ra, we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; exp_t e;
    send(1'b1, 64'h4002, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_ABCD);
    sb.push_back('{64'h0, 1'b0, 1'b0});
    serve(3, 64'hDEAD_BEEF_CAFE_F00D, rc, st, ra, a, wd, ws, we);
    checks++;
    if (rc !== 4 || st !== 1'b1 || ra !== 1'b0) begin
      failures++; $display("FAIL st_req_hold cycles=%0d stable=%b after=%b want 4/1/0", rc, st, ra);
    end
    checks++;
    if (a !== 32'h4002 || wd !== 64'hABCD_0000 || ws !== 8'h0C || we !== 1'b1) begin
      failures++; $display("FAIL st_bus addr=%h wdata=%h wstrb=%h wren=%b want 4002/abcd0000/0c/1", a, wd, ws, we);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL st_resp_valid got=%b want=1", resp_valid); sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if ({resp_rdata, resp_misalign, resp_err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL st_resp got=%h/%b/%b want=%h/0/0", resp_rdata, resp_misalign, resp_err, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    int reqs; exp_t e;
    send(1'b0, 64'h4006, 2'd2, 1'b0, 64'h0);
    sb.push_back('{64'h0, 1'b1, 1'b0});
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL mis_resp_valid got=%b want=1", resp_valid); sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if ({resp_rdata, resp_misalign, resp_err} !== {e.rdata, e.mis, e.err}) begin
        failures++; $display("FAIL mis_resp got=%h/%b/%b want=0/1/0", resp_rdata, resp_misalign, resp_err);
      end
    end
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (req !== 1'b0 || in_ready !== 1'b1) reqs++;
      @(negedge clk);
    end
    checks++;
    if (reqs !== 0) begin
      failures++; $display("FAIL mis_no_req bad_cycles=%0d want=0", reqs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int rc, pulses; logic st, ra, we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; exp_t e;
    send(1'b0, 64'h4010, 2'd3, 1'b0, 64'h0);
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || in_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_state req=%b ready=%b rv=%b want 0/1/0", req, in_ready, resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rvalid = 1'b1; rdata = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL rstmid_no_resp pulses=%0d want=0", pulses);
    end
    @(posedge clk); #1;
    send(1'b0, 64'h4020, 2'd2, 1'b1, 64'h0);
    sb.push_back('{64'h0000_0000_8765_4321, 1'b0, 1'b0});
    serve(1, 64'h8765_4321_8765_4321, rc, st, ra, a, wd, ws, we);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL rstmid_next_valid got=%b want=1", resp_valid); sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if (resp_rdata !== e.rdata) begin
        failures++; $display("FAIL rstmid_next_data got=%h want=%h", resp_rdata, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int rc; logic st, ra, we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; exp_t e;
    send(1'b0, 64'h4100, 2'd1, 1'b0, 64'h0);
    sb.push_back('{64'hFFFF_FFFF_FFFF_9001, 1'b0, 1'b0});
    serve(0, 64'h0000_0000_0000_9001, rc, st, ra, a, wd, ws, we);
    in_valid = 1'b1; in_we = 1'b0; in_addr = 64'h4104; in_size = 2'd2;
    in_unsigned = 1'b0; in_wdata = 64'h0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || in_ready !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL b2b_first valid=%b ready=%b want 1/1", resp_valid, in_ready); sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if (resp_rdata !== e.rdata) begin
        failures++; $display("FAIL b2b_first_data got=%h want=%h", resp_rdata, e.rdata);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{64'hFFFF_FFFF_C000_0001, 1'b0, 1'b0});
    serve(0, 64'hC000_0001_0000_0000, rc, st, ra, a, wd, ws, we);
    checks++;
    if (rc !== 1 || a !== 32'h4104) begin
      failures++; $display("FAIL b2b_second_req cycles=%0d addr=%h want 1/4104", rc, a);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL b2b_second_valid got=%b want=1", resp_valid); sb.delete();
    end else begin
      e = sb.pop_front();
      checks++;
      if (resp_rdata !== e.rdata) begin
        failures++; $display("FAIL b2b_second_data got=%h want=%h", resp_rdata, e.rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  // Random aligned accesses; expected lanes built byte by byte
  task automatic test_lanes();
    int rc, off, nb; logic st, ra, we, wr, uns; logic [1:0] sz;
    logic [31:0] a; logic [63:0] wd, ew, bus, ld, v, d; logic [7:0] ws, es; exp_t e;
    for (int k = 0; k < 12; k++) begin
      sz  = 2'($urandom_range(0, 3));
      nb  = 1 << sz;
      off = (int'($urandom_range(0, 7)) / nb) * nb;
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      bus = {$urandom, $urandom};
      ew = '0; es = '0; v = '0;
      for (int b = 0; b < nb; b++) begin
        ew[8*(off+b) +: 8] = d[8*b +: 8];
        es[off+b]          = 1'b1;
        v[8*b +: 8]        = bus[8*(off+b) +: 8];
      end
      ld = v;
      if (!uns && v[8*nb-1]) begin
        for (int b = nb; b < 8; b++) ld[8*b +: 8] = 8'hFF;
      end
      send(wr, 64'h8000 + 64'(off), sz, uns, d);
      sb.push_back('{wr ? 64'h0 : ld, 1'b0, 1'b0});
      serve(int'($urandom_range(0, 2)), bus, rc, st, ra, a, wd, ws, we);
      checks++;
      if (wr && (wd !== ew || ws !== es)) begin
        failures++; $display("FAIL lanes_store k=%0d sz=%0d off=%0d wdata=%h wstrb=%h want %h/%h", k, sz, off, wd, ws, ew, es);
      end else if (!wr && ws !== 8'h00) begin
        failures++; $display("FAIL lanes_load_strb k=%0d got=%h want=00", k, ws);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL lanes_valid k=%0d got=%b want=1", k, resp_valid); sb.delete();
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata) begin
          failures++; $display("FAIL lanes_data k=%0d sz=%0d off=%0d we=%b uns=%b got=%h want=%h", k, sz, off, wr, uns, resp_rdata, e.rdata);
        end
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int found, pulses; exp_t e;
    send(1'b0, 64'h4200, 2'd3, 1'b0, 64'h0);
    sb.push_back('{64'h0, 1'b0, 1'b1});
    found = -1;
    for (int i = 0; i < 40; i++) begin
      gnt = (i == 0);
      @(negedge clk);
      if (resp_valid === 1'b1) begin found = i; break; end
      @(posedge clk); #1;
    end
    gnt = 1'b0;
    checks++;
    if (found !== 16) begin
      failures++; $display("FAIL timeout_latency got=%0d want=16", found);
    end
    if (found >= 0 && sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({resp_rdata, resp_misalign, resp_err} !== {e.rdata, e.mis, e.err} || req !== 1'b0) begin
        failures++; $display("FAIL timeout_resp got=%h/%b/%b req=%b want 0/0/1 req=0", resp_rdata, resp_misalign, resp_err, req);
      end
    end else begin
      sb.delete();
    end
    @(posedge clk); #1;
    rvalid = 1'b1; rdata = 64'h1234;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = '0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || in_ready !== 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL timeout_late_rvalid bad_cycles=%0d want=0", pulses);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_addr = '0; in_size = '0;
    in_unsigned = 1'b0; in_wdata = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_dword();
    test_byte_ext();
    test_store_half_stall();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_lanes();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout got=hung want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
